// File: rtl/video_stream_gen_if.sv
// Pixel-source handshake and vsync/href/gray video stream bundled for video_stream_gen.
// The master side is the generator; the slave side is the source plus downstream consumer.
interface video_stream_gen_if;
  logic [7:0] src_data;
  logic       src_valid;
  logic       src_ready;
  logic       img_vsync;
  logic       img_href;
  logic [7:0] img_gray;
  logic       frame_start;
  logic       frame_done;
  logic       underflow;

  modport master (
    input  src_data,
    input  src_valid,
    output src_ready,
    output img_vsync,
    output img_href,
    output img_gray,
    output frame_start,
    output frame_done,
    output underflow
  );

  modport slave (
    output src_data,
    output src_valid,
    input  src_ready,
    input  img_vsync,
    input  img_href,
    input  img_gray,
    input  frame_start,
    input  frame_done,
    input  underflow
  );
endinterface

// File: rtl/video_stream_gen.sv
// Video stream transmitter: pulls gray pixels from a valid/ready source and emits a
// vsync/href/gray stream with fixed line and frame blanking; timing never stalls.
module video_stream_gen #(
  parameter logic [10:0] IMG_HDISP = 11'd640,
  parameter logic [10:0] IMG_VDISP = 11'd480,
  parameter logic [10:0] H_BLANK   = 11'd160,
  parameter logic [10:0] V_PRE     = 11'd2,
  parameter logic [10:0] V_POST    = 11'd2,
  parameter logic [10:0] V_GAP     = 11'd4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  video_stream_gen_if.master stream
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_ACT  = 3'd2,
    ST_POST = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  localparam logic [10:0] LINE_LAST = IMG_HDISP + H_BLANK - 11'd1;

  state_t      state_r;
  state_t      state_nxt_s;
  state_t      state_succ_s;
  logic [10:0] hcnt_r;
  logic [10:0] hcnt_nxt_s;
  logic [10:0] vcnt_r;
  logic [10:0] vcnt_nxt_s;
  logic [10:0] lines_last_s;
  logic        line_end_s;
  logic        pix_act_s;
  logic        vsync_d_s;
  logic [7:0]  gray_d_s;
  logic        underflow_d_s;

  logic        vsync_r;
  logic        href_r;
  logic [7:0]  gray_r;
  logic        frame_start_r;
  logic        frame_done_r;
  logic        underflow_r;

  assign line_end_s = (hcnt_r == LINE_LAST);
  assign pix_act_s  = (state_r == ST_ACT) && (hcnt_r < IMG_HDISP);
  assign vsync_d_s  = (state_r == ST_PRE) || (state_r == ST_ACT) || (state_r == ST_POST);

  // Last line index of the current vertical section, and the section that follows it.
  always_comb begin
    lines_last_s = 11'd0;
    state_succ_s = ST_IDLE;
    case (state_r)
      ST_PRE: begin
        lines_last_s = V_PRE - 11'd1;
        state_succ_s = ST_ACT;
      end
      ST_ACT: begin
        lines_last_s = IMG_VDISP - 11'd1;
        state_succ_s = ST_POST;
      end
      ST_POST: begin
        lines_last_s = V_POST - 11'd1;
        state_succ_s = ST_GAP;
      end
      ST_GAP: begin
        lines_last_s = V_GAP - 11'd1;
        if (enable) begin
          state_succ_s = ST_PRE;
        end else begin
          state_succ_s = ST_IDLE;
        end
      end
      default: begin
        lines_last_s = 11'd0;
        state_succ_s = ST_IDLE;
      end
    endcase
  end

  // Next-state and timing counter logic; enable only matters in IDLE and at the end of GAP.
  always_comb begin
    state_nxt_s = state_r;
    hcnt_nxt_s  = hcnt_r;
    vcnt_nxt_s  = vcnt_r;
    case (state_r)
      ST_IDLE: begin
        hcnt_nxt_s = 11'd0;
        vcnt_nxt_s = 11'd0;
        if (enable) begin
          state_nxt_s = ST_PRE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PRE, ST_ACT, ST_POST, ST_GAP: begin
        if (line_end_s) begin
          hcnt_nxt_s = 11'd0;
          if (vcnt_r == lines_last_s) begin
            vcnt_nxt_s  = 11'd0;
            state_nxt_s = state_succ_s;
          end else begin
            vcnt_nxt_s = vcnt_r + 11'd1;
          end
        end else begin
          hcnt_nxt_s = hcnt_r + 11'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        hcnt_nxt_s  = 11'd0;
        vcnt_nxt_s  = 11'd0;
      end
    endcase
  end

  // State and timing counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      hcnt_r  <= 11'd0;
      vcnt_r  <= 11'd0;
    end else begin
      state_r <= state_nxt_s;
      hcnt_r  <= hcnt_nxt_s;
      vcnt_r  <= vcnt_nxt_s;
    end
  end

  // Pixel value to present and the sticky starvation flag for the coming clock.
  always_comb begin
    gray_d_s      = 8'd0;
    underflow_d_s = underflow_r;
    if (pix_act_s && stream.src_valid) begin
      gray_d_s = stream.src_data;
    end else begin
      gray_d_s = 8'd0;
    end
    // A new frame wipes the flag; starvation cannot happen on that same clock (PRE).
    if (vsync_d_s && !vsync_r) begin
      underflow_d_s = 1'b0;
    end else if (pix_act_s && !stream.src_valid) begin
      underflow_d_s = 1'b1;
    end else begin
      underflow_d_s = underflow_r;
    end
  end

  // Registered stream outputs, one clock behind the timing counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_r       <= 1'b0;
      href_r        <= 1'b0;
      gray_r        <= 8'd0;
      frame_start_r <= 1'b0;
      frame_done_r  <= 1'b0;
      underflow_r   <= 1'b0;
    end else begin
      vsync_r       <= vsync_d_s;
      href_r        <= pix_act_s;
      gray_r        <= gray_d_s;
      frame_start_r <= vsync_d_s & ~vsync_r;
      frame_done_r  <= ~vsync_d_s & vsync_r;
      underflow_r   <= underflow_d_s;
    end
  end

  assign stream.src_ready   = pix_act_s;
  assign stream.img_vsync   = vsync_r;
  assign stream.img_href    = href_r;
  assign stream.img_gray    = gray_r;
  assign stream.frame_start = frame_start_r;
  assign stream.frame_done  = frame_done_r;
  assign stream.underflow   = underflow_r;

endmodule

// File: tb/tb_video_stream_gen.sv
// Self-checking bench for video_stream_gen: a frame-position reference model predicts every
// registered output each clock; scenario tasks add frame-level counts and boundary checks.
module tb_video_stream_gen;
  localparam int HD_I    = 8;
  localparam int VD_I    = 4;
  localparam int HB_I    = 4;
  localparam int VPRE_I  = 1;
  localparam int VPOST_I = 1;
  localparam int VGAP_I  = 2;
  localparam int L       = HD_I + HB_I;
  localparam int VS_CLKS = (VPRE_I + VD_I + VPOST_I) * L;
  localparam int FRAME   = (VPRE_I + VD_I + VPOST_I + VGAP_I) * L;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic [7:0] next_pix;
  int checks = 0;
  int failures = 0;

  video_stream_gen_if ifc ();

  video_stream_gen #(
    .IMG_HDISP(11'd8), .IMG_VDISP(11'd4), .H_BLANK(11'd4),
    .V_PRE(11'd1), .V_POST(11'd1), .V_GAP(11'd2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .stream(ifc.master)
  );

  always #5 clk = ~clk;

  // Reference model: m_pos is the clock index within a running frame (0 = first PRE clock).
  bit m_run;
  int m_pos;
  logic e_vsync, e_href, e_fs, e_fd, e_uf;
  logic [7:0] e_gray;
  logic m_vs, m_act;

  function automatic logic pos_act(input bit run, input int p);
    int line;
    int col;
    line = p / L;
    col  = p % L;
    return run && (line >= VPRE_I) && (line < VPRE_I + VD_I) && (col < HD_I);
  endfunction

  assign m_vs  = m_run && (m_pos < VS_CLKS);
  assign m_act = pos_act(m_run, m_pos);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0; m_pos <= 0;
      e_vsync <= 1'b0; e_href <= 1'b0; e_gray <= 8'd0;
      e_fs <= 1'b0; e_fd <= 1'b0; e_uf <= 1'b0;
    end else begin
      e_vsync <= m_vs;
      e_href  <= m_act;
      e_gray  <= (m_act && ifc.src_valid) ? ifc.src_data : 8'd0;
      e_fs    <= m_vs && !e_vsync;
      e_fd    <= !m_vs && e_vsync;
      if (m_vs && !e_vsync) e_uf <= 1'b0;
      else if (m_act && !ifc.src_valid) e_uf <= 1'b1;
      if (!m_run || (m_pos == FRAME - 1)) begin
        m_run <= enable;
        m_pos <= 0;
      end else begin
        m_pos <= m_pos + 1;
      end
    end
  end

  wire [12:0] obs_w = {ifc.img_vsync, ifc.img_href, ifc.img_gray, ifc.frame_start, ifc.frame_done, ifc.underflow};
  wire [12:0] exp_w = {e_vsync, e_href, e_gray, e_fs, e_fd, e_uf};

  // One clock of source stimulus; the source advances only on an accepted transfer.
  task automatic tick(input bit v, output bit took);
    ifc.src_valid = v;
    ifc.src_data  = next_pix;
    #1;
    took = ifc.src_ready && v;
    @(posedge clk);
    if (took) next_pix = next_pix + 8'd1;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; enable = 1'b0; ifc.src_valid = 1'b0; ifc.src_data = 8'd0; next_pix = 8'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bit took;
    @(negedge clk);
    rst_n = 1'b0; enable = 1'b0; ifc.src_valid = 1'b0; ifc.src_data = 8'd0; next_pix = 8'd0;
    #1;
    checks++;
    if (obs_w !== 13'd0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", obs_w); end
    checks++;
    if (ifc.src_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ifc.src_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, took);
      checks++;
      if (obs_w !== 13'd0 || ifc.src_ready !== 1'b0) begin
        failures++; $display("FAIL idle_quiet cyc=%0d got=%h ready=%b exp=0", i, obs_w, ifc.src_ready);
      end
    end
  endtask

  task automatic test_stream();
    bit took;
    int vs_cnt = 0, href_cnt = 0, fs_cnt = 0, fd_cnt = 0, uf_cnt = 0, pix_idx = 0;
    apply_reset();
    enable = 1'b1;
    for (int t = 1; t <= 1 + 2 * FRAME; t++) begin
      tick(1'b1, took);
      checks++;
      if (obs_w !== exp_w) begin failures++; $display("FAIL stream_out t=%0d got=%h exp=%h", t, obs_w, exp_w); end
      checks++;
      if (ifc.src_ready !== m_act) begin failures++; $display("FAIL stream_ready t=%0d got=%b exp=%b", t, ifc.src_ready, m_act); end
      if (ifc.img_href) begin
        checks++;
        if (ifc.img_gray !== 8'(pix_idx)) begin failures++; $display("FAIL stream_gray idx=%0d got=%0d exp=%0d", pix_idx, ifc.img_gray, pix_idx); end
        pix_idx++;
      end
      vs_cnt += int'(ifc.img_vsync); href_cnt += int'(ifc.img_href);
      fs_cnt += int'(ifc.frame_start); fd_cnt += int'(ifc.frame_done); uf_cnt += int'(ifc.underflow);
    end
    checks++;
    if (vs_cnt != 2 * VS_CLKS) begin failures++; $display("FAIL stream_vsync_clks got=%0d exp=%0d", vs_cnt, 2 * VS_CLKS); end
    checks++;
    if (href_cnt != 2 * HD_I * VD_I) begin failures++; $display("FAIL stream_href_clks got=%0d exp=%0d", href_cnt, 2 * HD_I * VD_I); end
    checks++;
    if (fs_cnt != 2 || fd_cnt != 2) begin failures++; $display("FAIL stream_pulses got fs=%0d fd=%0d exp 2/2", fs_cnt, fd_cnt); end
    checks++;
    if (uf_cnt != 0) begin failures++; $display("FAIL stream_underflow got=%0d exp=0", uf_cnt); end
  endtask

  task automatic test_underflow();
    bit took, v, dropped = 1'b0;
    int uf_cnt = 0, pix_idx = 0, fs_seen = 0;
    apply_reset();
    enable = 1'b1;
    for (int t = 1; t <= 1 + 2 * FRAME; t++) begin
      v = 1'b1;
      if (!dropped && m_run && m_pos == (VPRE_I + 1) * L + 2) begin v = 1'b0; dropped = 1'b1; end
      tick(v, took);
      checks++;
      if (obs_w !== exp_w) begin failures++; $display("FAIL uflow_out t=%0d got=%h exp=%h", t, obs_w, exp_w); end
      if (ifc.img_href && pix_idx < HD_I * VD_I) begin
        if (pix_idx == HD_I + 2) begin
          checks++;
          if (ifc.img_gray !== 8'd0) begin failures++; $display("FAIL uflow_pixel got=%0d exp=0", ifc.img_gray); end
        end
        pix_idx++;
      end
      if (ifc.frame_start) begin
        fs_seen++;
        if (fs_seen == 2) begin
          checks++;
          if (ifc.underflow !== 1'b0) begin failures++; $display("FAIL uflow_clear got=%b exp=0", ifc.underflow); end
        end
      end
      uf_cnt += int'(ifc.underflow);
    end
    checks++;
    if (uf_cnt != FRAME - ((VPRE_I + 1) * L + 2)) begin
      failures++; $display("FAIL uflow_span got=%0d exp=%0d", uf_cnt, FRAME - ((VPRE_I + 1) * L + 2));
    end
  endtask

  task automatic test_enable_drop();
    bit took;
    int vs_cnt = 0, fs_cnt = 0, fd_cnt = 0;
    apply_reset();
    enable = 1'b1;
    for (int t = 1; t <= 3 * FRAME; t++) begin
      if (m_run && m_pos == 30) enable = 1'b0;
      tick(1'b1, took);
      checks++;
      if (obs_w !== exp_w) begin failures++; $display("FAIL drop_out t=%0d got=%h exp=%h", t, obs_w, exp_w); end
      vs_cnt += int'(ifc.img_vsync); fs_cnt += int'(ifc.frame_start); fd_cnt += int'(ifc.frame_done);
    end
    checks++;
    if (vs_cnt != VS_CLKS) begin failures++; $display("FAIL drop_vsync_clks got=%0d exp=%0d", vs_cnt, VS_CLKS); end
    checks++;
    if (fs_cnt != 1 || fd_cnt != 1) begin failures++; $display("FAIL drop_pulses got fs=%0d fd=%0d exp 1/1", fs_cnt, fd_cnt); end
  endtask

  task automatic test_mid_reset();
    bit took;
    int guard = 0, first_href = -1;
    apply_reset();
    enable = 1'b1;
    while (!(m_run && m_pos == 2 * L + 3) && guard < 4 * FRAME) begin tick(1'b1, took); guard++; end
    checks++;
    if (guard >= 4 * FRAME) begin failures++; $display("FAIL midrst_reach_act got=timeout exp=ACT"); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_w !== 13'd0 || ifc.src_ready !== 1'b0) begin
      failures++; $display("FAIL midrst_async got=%h ready=%b exp=0", obs_w, ifc.src_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 1; t <= 3 * L && first_href < 0; t++) begin
      tick(1'b1, took);
      checks++;
      if (obs_w !== exp_w) begin failures++; $display("FAIL midrst_out t=%0d got=%h exp=%h", t, obs_w, exp_w); end
      if (ifc.img_href) first_href = t;
    end
    checks++;
    if (first_href - 1 != VPRE_I * L + 1) begin
      failures++; $display("FAIL midrst_first_href got=%0d exp=%0d", first_href - 1, VPRE_I * L + 1);
    end
  endtask

  task automatic test_random();
    bit took, v;
    int ready_cnt[3] = '{0, 0, 0};
    int consumed = 0, exp_consumed = 0, fs_cnt = 0, fd_cnt = 0;
    apply_reset();
    enable = 1'b1;
    for (int t = 1; t <= 1 + 3 * FRAME; t++) begin
      v = ($urandom_range(0, 3) != 0);
      if (m_act && v) exp_consumed++;
      tick(v, took);
      consumed += int'(took);
      checks++;
      if (obs_w !== exp_w) begin failures++; $display("FAIL rand_out t=%0d got=%h exp=%h", t, obs_w, exp_w); end
      checks++;
      if (ifc.src_ready !== m_act) begin failures++; $display("FAIL rand_ready t=%0d got=%b exp=%b", t, ifc.src_ready, m_act); end
      if (t - 1 < 3 * FRAME) ready_cnt[(t - 1) / FRAME] += int'(ifc.src_ready);
      fs_cnt += int'(ifc.frame_start); fd_cnt += int'(ifc.frame_done);
    end
    for (int f = 0; f < 3; f++) begin
      checks++;
      if (ready_cnt[f] != HD_I * VD_I) begin failures++; $display("FAIL rand_ready_clks frame=%0d got=%0d exp=%0d", f, ready_cnt[f], HD_I * VD_I); end
    end
    checks++;
    if (consumed != exp_consumed) begin failures++; $display("FAIL rand_consumed got=%0d exp=%0d", consumed, exp_consumed); end
    checks++;
    if (fs_cnt != 3 || fd_cnt != 3) begin failures++; $display("FAIL rand_pulses got fs=%0d fd=%0d exp 3/3", fs_cnt, fd_cnt); end
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    ifc.src_valid = 1'b0;
    ifc.src_data = 8'd0;
    next_pix = 8'd0;
    test_reset();
    test_stream();
    test_underflow();
    test_enable_drop();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
